// File: rtl/rf_16_4_pkg.sv
// Shared geometry constants and enums for the 16x4 register-file write-port controller.
package rf_16_4_pkg;

   localparam int RF_ENTRIES = 16;
   localparam int RF_ADDR_W  = 4;
   localparam int RF_DATA_W  = 4;

   localparam logic [RF_ADDR_W-1:0] RF_LAST_ADDR = RF_ADDR_W'(RF_ENTRIES - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } rf_state_t;

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } rf_grant_t;

endpackage

// File: rtl/rf_rr_arb_2.sv
// Two-input round-robin arbiter: one-hot grant and the updated last-grant marker.
module rf_rr_arb_2
   import rf_16_4_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       next_last_grant
);

   always_comb begin
      grant           = 2'b00;
      next_last_grant = last_grant;
      case (req)
         2'b01: grant = 2'b01;
         2'b10: grant = 2'b10;
         2'b11: begin
            // The marker only moves under contention; a lone requester leaves it alone.
            if (last_grant == GRANT_B) begin
               grant           = 2'b01;
               next_last_grant = GRANT_A;
            end else begin
               grant           = 2'b10;
               next_last_grant = GRANT_B;
            end
         end
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/rf_16_4_write_arbiter.sv
// Write-port controller for the 16x4 register file: round-robin A/B arbitration,
// registered write port, and a 16-entry zero-clear sequencer run after reset or on request.
module rf_16_4_write_arbiter
   import rf_16_4_pkg::*;
(
   input  logic                 rf_clock,
   input  logic                 rf_reset,
   input  logic                 a_req,
   input  logic [RF_ADDR_W-1:0] a_addr,
   input  logic [RF_DATA_W-1:0] a_data,
   output logic                 a_ack,
   input  logic                 b_req,
   input  logic [RF_ADDR_W-1:0] b_addr,
   input  logic [RF_DATA_W-1:0] b_data,
   output logic                 b_ack,
   input  logic                 clear_req,
   output logic                 clear_busy,
   output logic                 clear_done,
   output logic                 rf_wr_enable,
   output logic [RF_ADDR_W-1:0] rf_wr_addr,
   output logic [RF_DATA_W-1:0] rf_wr_data
);

   rf_state_t            state_reg, state_next;
   logic [RF_ADDR_W-1:0] clear_cnt_reg, clear_cnt_next;
   logic                 last_grant_reg, last_grant_next;
   logic                 wr_enable_next, clear_done_next;
   logic [RF_ADDR_W-1:0] wr_addr_next;
   logic [RF_DATA_W-1:0] wr_data_next;
   logic [1:0]           arb_req, arb_grant;
   logic                 arb_next_last;

   // Requests only reach the arbiter in IDLE when no clear is being started.
   assign arb_req = (state_reg == IDLE && !clear_req) ? {b_req, a_req} : 2'b00;

   rf_rr_arb_2 u_arb (
      .req             (arb_req),
      .last_grant      (last_grant_reg),
      .grant           (arb_grant),
      .next_last_grant (arb_next_last)
   );

   assign a_ack      = arb_grant[0];
   assign b_ack      = arb_grant[1];
   assign clear_busy = (state_reg == CLEAR);

   always_comb begin
      state_next      = state_reg;
      clear_cnt_next  = clear_cnt_reg;
      last_grant_next = last_grant_reg;
      wr_enable_next  = 1'b0;
      wr_addr_next    = rf_wr_addr;
      wr_data_next    = rf_wr_data;
      clear_done_next = 1'b0;
      case (state_reg)
         CLEAR: begin
            wr_enable_next = 1'b1;
            wr_addr_next   = clear_cnt_reg;
            wr_data_next   = '0;
            clear_cnt_next = clear_cnt_reg + RF_ADDR_W'(1);
            if (clear_cnt_reg == RF_LAST_ADDR) begin
               state_next      = IDLE;
               clear_done_next = 1'b1;
            end
         end
         IDLE: begin
            if (clear_req) begin
               state_next = CLEAR;
            end else begin
               last_grant_next = arb_next_last;
               if (arb_grant[0]) begin
                  wr_enable_next = 1'b1;
                  wr_addr_next   = a_addr;
                  wr_data_next   = a_data;
               end else if (arb_grant[1]) begin
                  wr_enable_next = 1'b1;
                  wr_addr_next   = b_addr;
                  wr_data_next   = b_data;
               end
            end
         end
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge rf_clock or posedge rf_reset) begin
      if (rf_reset) begin
         state_reg      <= CLEAR;
         clear_cnt_reg  <= '0;
         last_grant_reg <= GRANT_B;
         rf_wr_enable   <= 1'b0;
         rf_wr_addr     <= '0;
         rf_wr_data     <= '0;
         clear_done     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         clear_cnt_reg  <= clear_cnt_next;
         last_grant_reg <= last_grant_next;
         rf_wr_enable   <= wr_enable_next;
         rf_wr_addr     <= wr_addr_next;
         rf_wr_data     <= wr_data_next;
         clear_done     <= clear_done_next;
      end
   end

endmodule

// File: tb/tb_rf_16_4_write_arbiter.sv
// Directed self-checking bench for rf_16_4_write_arbiter with a watching model of the macro.
module tb_rf_16_4_write_arbiter;

   logic       rf_clock, rf_reset;
   logic       a_req, b_req, clear_req;
   logic [3:0] a_addr, a_data, b_addr, b_data;
   logic       a_ack, b_ack, clear_busy, clear_done, rf_wr_enable;
   logic [3:0] rf_wr_addr, rf_wr_data;

   int checks   = 0;
   int failures = 0;

   logic [3:0] mem [16] = '{default: 4'hF};

   rf_16_4_write_arbiter dut (
      .rf_clock     (rf_clock),
      .rf_reset     (rf_reset),
      .a_req        (a_req),
      .a_addr       (a_addr),
      .a_data       (a_data),
      .a_ack        (a_ack),
      .b_req        (b_req),
      .b_addr       (b_addr),
      .b_data       (b_data),
      .b_ack        (b_ack),
      .clear_req    (clear_req),
      .clear_busy   (clear_busy),
      .clear_done   (clear_done),
      .rf_wr_enable (rf_wr_enable),
      .rf_wr_addr   (rf_wr_addr),
      .rf_wr_data   (rf_wr_data)
   );

   initial rf_clock = 1'b0;
   always #5 rf_clock = ~rf_clock;

   // Model of the macro's write port: an enabled write lands at the edge ending its cycle.
   always @(posedge rf_clock)
      if (rf_wr_enable === 1'b1) mem[rf_wr_addr] <= rf_wr_data;

   task automatic tick;
      @(posedge rf_clock);
      #1;
   endtask

   task automatic test_reset;
      rf_reset = 1'b1; a_req = 0; b_req = 0; clear_req = 0;
      a_addr = 0; a_data = 0; b_addr = 0; b_data = 0;
      tick;
      checks++;
      if ({rf_wr_enable, rf_wr_addr, rf_wr_data, clear_done, clear_busy, a_ack, b_ack} !== {1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state: en=%b addr=%0d data=%0d done=%b busy=%b ack=%b%b required 0/0/0/0/1/00",
                  rf_wr_enable, rf_wr_addr, rf_wr_data, clear_done, clear_busy, a_ack, b_ack);
      end
      rf_reset = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick;
         checks++;
         if ({rf_wr_enable, rf_wr_addr, rf_wr_data} !== {1'b1, 4'(i - 1), 4'd0}) begin
            failures++;
            $display("FAIL reset_clear_write[%0d]: en=%b addr=%0d data=%0d required 1/%0d/0",
                     i, rf_wr_enable, rf_wr_addr, rf_wr_data, i - 1);
         end
         checks++;
         if ({clear_done, clear_busy} !== {(i == 16), (i < 16)}) begin
            failures++;
            $display("FAIL reset_clear_flags[%0d]: done=%b busy=%b required %b/%b",
                     i, clear_done, clear_busy, (i == 16), (i < 16));
         end
      end
      tick;
      checks++;
      if ({clear_done, rf_wr_enable} !== 2'b00) begin
         failures++;
         $display("FAIL reset_after_clear: done=%b en=%b required 0/0", clear_done, rf_wr_enable);
      end
      for (int e = 0; e < 16; e++) begin
         checks++;
         if (mem[e] !== 4'h0) begin
            failures++;
            $display("FAIL reset_mem[%0d]: got %h required 0", e, mem[e]);
         end
      end
      $display("reset release: clear of 16 entries observed");
   endtask

   task automatic test_a_only;
      a_req = 1; a_addr = 4'd5; a_data = 4'hA;
      #1;
      checks++;
      if ({a_ack, b_ack} !== 2'b10) begin
         failures++;
         $display("FAIL a_only_ack: a_ack=%b b_ack=%b required 1/0", a_ack, b_ack);
      end
      tick;
      a_req = 0;
      checks++;
      if ({rf_wr_enable, rf_wr_addr, rf_wr_data, mem[5]} !== {1'b1, 4'd5, 4'hA, 4'h0}) begin
         failures++;
         $display("FAIL a_only_write: en=%b addr=%0d data=%h mem5=%h required 1/5/a/0",
                  rf_wr_enable, rf_wr_addr, rf_wr_data, mem[5]);
      end
      tick;
      checks++;
      if ({mem[5], rf_wr_enable, rf_wr_addr} !== {4'hA, 1'b0, 4'd5}) begin
         failures++;
         $display("FAIL a_only_landed: mem5=%h en=%b addr=%0d required a/0/5", mem[5], rf_wr_enable, rf_wr_addr);
      end
      $display("a only: addr 5 data a written");
   endtask

   task automatic test_contention;
      logic exp_a;
      a_req = 1; a_addr = 4'd1; a_data = 4'h1;
      b_req = 1; b_addr = 4'd2; b_data = 4'h2;
      for (int k = 0; k < 6; k++) begin
         exp_a = (k % 2 == 0);
         #1;
         checks++;
         if ({a_ack, b_ack} !== {exp_a, !exp_a}) begin
            failures++;
            $display("FAIL contention_ack[%0d]: a_ack=%b b_ack=%b required %b/%b", k, a_ack, b_ack, exp_a, !exp_a);
         end
         tick;
         checks++;
         if ({rf_wr_enable, rf_wr_addr, rf_wr_data} !== {1'b1, exp_a ? 4'd1 : 4'd2, exp_a ? 4'h1 : 4'h2}) begin
            failures++;
            $display("FAIL contention_write[%0d]: en=%b addr=%0d data=%h", k, rf_wr_enable, rf_wr_addr, rf_wr_data);
         end
         $display("contention cycle %0d: granted %s", k, exp_a ? "A" : "B");
      end
      a_req = 0; b_req = 0;
      tick;
   endtask

   task automatic test_clear_with_a_pending;
      clear_req = 1; a_req = 1; a_addr = 4'd3; a_data = 4'h7;
      #1;
      checks++;
      if (a_ack !== 1'b0) begin
         failures++;
         $display("FAIL clear_prio_ack0: a_ack=%b required 0", a_ack);
      end
      tick;
      clear_req = 0;
      for (int i = 1; i <= 16; i++) begin
         #1;
         checks++;
         if ({clear_busy, a_ack} !== 2'b10) begin
            failures++;
            $display("FAIL clear_prio_busy[%0d]: busy=%b a_ack=%b required 1/0", i, clear_busy, a_ack);
         end
         if (i >= 2) begin
            checks++;
            if ({rf_wr_enable, rf_wr_addr} !== {1'b1, 4'(i - 2)}) begin
               failures++;
               $display("FAIL clear_prio_write[%0d]: en=%b addr=%0d required 1/%0d", i, rf_wr_enable, rf_wr_addr, i - 2);
            end
         end
         tick;
      end
      #1;
      checks++;
      if ({clear_busy, a_ack, clear_done, rf_wr_addr} !== {1'b0, 1'b1, 1'b1, 4'd15}) begin
         failures++;
         $display("FAIL clear_prio_end: busy=%b a_ack=%b done=%b addr=%0d required 0/1/1/15",
                  clear_busy, a_ack, clear_done, rf_wr_addr);
      end
      tick;
      a_req = 0;
      checks++;
      if ({rf_wr_enable, rf_wr_addr, rf_wr_data} !== {1'b1, 4'd3, 4'h7}) begin
         failures++;
         $display("FAIL clear_prio_a_write: en=%b addr=%0d data=%h required 1/3/7", rf_wr_enable, rf_wr_addr, rf_wr_data);
      end
      tick;
      checks++;
      if (mem[3] !== 4'h7) begin
         failures++;
         $display("FAIL clear_prio_mem3: got %h required 7", mem[3]);
      end
      $display("clear with A pending: A written after clear");
   endtask

   task automatic test_clear_req_during_clear;
      int writes, dones;
      writes = 0; dones = 0;
      clear_req = 1;
      for (int i = 1; i <= 20; i++) begin
         tick;
         if (i == 15) clear_req = 0;
         if (rf_wr_enable === 1'b1) writes++;
         if (clear_done === 1'b1) dones++;
      end
      checks++;
      if (writes !== 16 || dones !== 1) begin
         failures++;
         $display("FAIL clear_no_restart: writes=%0d dones=%0d required 16/1", writes, dones);
      end
      checks++;
      if ({mem[3], mem[5]} !== 8'h00) begin
         failures++;
         $display("FAIL clear_no_restart_mem: mem3=%h mem5=%h required 0/0", mem[3], mem[5]);
      end
      $display("clear_req held during clear: %0d writes, %0d done pulses", writes, dones);
   endtask

   task automatic test_reset_mid_clear;
      clear_req = 1;
      tick;
      clear_req = 0;
      for (int i = 0; i < 9; i++) tick;
      checks++;
      if ({rf_wr_enable, rf_wr_addr} !== {1'b1, 4'd8}) begin
         failures++;
         $display("FAIL mid_clear_before: en=%b addr=%0d required 1/8", rf_wr_enable, rf_wr_addr);
      end
      #3;
      rf_reset = 1'b1;
      #1;
      checks++;
      if ({rf_wr_enable, rf_wr_addr, clear_busy} !== {1'b0, 4'd0, 1'b1}) begin
         failures++;
         $display("FAIL mid_clear_async: en=%b addr=%0d busy=%b required 0/0/1", rf_wr_enable, rf_wr_addr, clear_busy);
      end
      tick;
      rf_reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick;
         checks++;
         if ({rf_wr_enable, rf_wr_addr} !== {1'b1, 4'(i)}) begin
            failures++;
            $display("FAIL mid_clear_restart[%0d]: en=%b addr=%0d required 1/%0d", i, rf_wr_enable, rf_wr_addr, i);
         end
      end
      for (int i = 0; i < 16; i++) tick;
      checks++;
      if ({clear_busy, rf_wr_enable} !== 2'b00) begin
         failures++;
         $display("FAIL mid_clear_finish: busy=%b en=%b required 0/0", clear_busy, rf_wr_enable);
      end
      $display("reset mid-clear: clear restarted from entry 0");
   endtask

   initial begin
      test_reset;
      test_a_only;
      test_contention;
      test_clear_with_a_pending;
      test_clear_req_during_clear;
      test_reset_mid_clear;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
